// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider plus h/v counters with decoded syncs and blanking.
// All outputs decode directly from the counter registers (zero latency); free-running, no backpressure.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_MAX     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;
  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;

  // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so the tick is permanently high.
  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d     = div_q + 4'd1;
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (pix_tick) begin
      div_d = '0;
      if (h_count_q == H_MAX) begin
        h_count_d = '0;
        if (v_count_q == V_MAX) begin
          v_count_d = '0;
        end else begin
          v_count_d = v_count_q + 10'd1;
        end
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      div_q     <= div_d;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  assign pix_x       = h_count_q;
  assign pix_y       = v_count_q;
  assign video_on    = (h_count_q < H_VIS) && (v_count_q < V_VIS);
  assign hsync       = !((h_count_q >= H_SYNC_LO) && (h_count_q <= H_SYNC_HI));
  assign vsync       = !((v_count_q >= V_SYNC_LO) && (v_count_q <= V_SYNC_HI));
  assign line_start  = pix_tick && (h_count_q == 10'd0);
  assign frame_start = line_start && (v_count_q == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-parameter instance plus a tiny CLK_DIV=1 raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic       d0_tick, d0_hs, d0_vs, d0_von, d0_ls, d0_fs;
  logic [9:0] d0_x, d0_y;
  logic       d1_tick, d1_hs, d1_vs, d1_von, d1_ls, d1_fs;
  logic [9:0] d1_x, d1_y;

  int tot = 0;
  int bad = 0;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst0_n), .pix_tick(d0_tick), .hsync(d0_hs), .vsync(d0_vs),
    .video_on(d0_von), .pix_x(d0_x), .pix_y(d0_y), .line_start(d0_ls), .frame_start(d0_fs)
  );

  // 15 x 8 raster: hsync low x=10..12, vsync low y=5..6, visible 8 x 4.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .pix_tick(d1_tick), .hsync(d1_hs), .vsync(d1_vs),
    .video_on(d1_von), .pix_x(d1_x), .pix_y(d1_y), .line_start(d1_ls), .frame_start(d1_fs)
  );

  typedef struct {
    int idx; int x; int y;
    bit hs; bit vs; bit von; bit ls; bit fs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t mk(int idx, int x, int y, bit hs, bit vs, bit von, bit ls, bit fs);
    exp_t e;
    e.idx = idx; e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.von = von; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    tot++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cmp(input string name, input int idx, input exp_t e, input int x, input int y,
                     input bit hs, input bit vs, input bit von, input bit ls, input bit fs);
    tot++;
    if (x != e.x || y != e.y || hs != e.hs || vs != e.vs || von != e.von || ls != e.ls || fs != e.fs) begin
      bad++;
      $display("FAIL %s tick=%0d got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b exp x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
               name, idx, x, y, hs, vs, von, ls, fs, e.x, e.y, e.hs, e.vs, e.von, e.ls, e.fs);
    end
  endtask

  // Monitors: tick index counts pix_ticks since the last observed reset.
  int idx0 = 0;
  int idx1 = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst0_n) idx0 = 0;
      else if (d0_tick) begin
        if (q0.size() > 0 && q0[0].idx == idx0) begin
          e = q0.pop_front();
          cmp("sb0", idx0, e, int'(d0_x), int'(d0_y), d0_hs, d0_vs, d0_von, d0_ls, d0_fs);
        end
        idx0++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst1_n) idx1 = 0;
      else if (d1_tick) begin
        if (q1.size() > 0 && q1[0].idx == idx1) begin
          e = q1.pop_front();
          cmp("sb1", idx1, e, int'(d1_x), int'(d1_y), d1_hs, d1_vs, d1_von, d1_ls, d1_fs);
        end
        idx1++;
      end
    end
  end

  task automatic wait_empty(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? q0.size() : q1.size()) > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk((which == 0) ? "sb0_drained" : "sb1_drained", (which == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic next_tick0(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d0_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tot++;
      bad++;
      $display("FAIL tick_timeout got=no_tick exp=tick within 8 clks");
    end
  endtask

  task automatic check_reset0(input string tag);
    chk({tag, "_tick"}, int'(d0_tick), 0);
    chk({tag, "_x"},    int'(d0_x),    0);
    chk({tag, "_y"},    int'(d0_y),    0);
    chk({tag, "_von"},  int'(d0_von),  1);
    chk({tag, "_hs"},   int'(d0_hs),   1);
    chk({tag, "_vs"},   int'(d0_vs),   1);
    chk({tag, "_ls"},   int'(d0_ls),   0);
    chk({tag, "_fs"},   int'(d0_fs),   0);
  endtask

  task automatic first_tick0(input string tag);
    int cnt;
    cnt = 1;
    while (!d0_tick && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_clk"}, cnt, 4);
    chk({tag, "_fs"},  int'(d0_fs), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, von_cnt, hs_cnt, hs_first, hs_last;
    int ls_c, fs_c, von_c, vs_c, hs_c, tk_c;

    rst0_n = 1'b0;
    rst1_n = 1'b0;

    // idx = x + 800*y for the default raster
    q0.push_back(mk(0,    0,   0, 1, 1, 1, 1, 1));
    q0.push_back(mk(1,    1,   0, 1, 1, 1, 0, 0));
    q0.push_back(mk(639,  639, 0, 1, 1, 1, 0, 0));
    q0.push_back(mk(640,  640, 0, 1, 1, 0, 0, 0));
    q0.push_back(mk(655,  655, 0, 1, 1, 0, 0, 0));
    q0.push_back(mk(656,  656, 0, 0, 1, 0, 0, 0));
    q0.push_back(mk(751,  751, 0, 0, 1, 0, 0, 0));
    q0.push_back(mk(752,  752, 0, 1, 1, 0, 0, 0));
    q0.push_back(mk(799,  799, 0, 1, 1, 0, 0, 0));
    q0.push_back(mk(800,  0,   1, 1, 1, 1, 1, 0));
    q0.push_back(mk(1200, 400, 1, 1, 1, 1, 0, 0));
    q0.push_back(mk(2000, 400, 2, 1, 1, 1, 0, 0));

    repeat (3) @(negedge clk);
    check_reset0("rst0");
    rst0_n = 1'b1;
    first_tick0("first_tick");

    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!d0_tick && n < 20);
      chk("tick_spacing", n, 4);
    end

    n = 0;
    do begin
      next_tick0(ok);
      n++;
    end while (ok && !(d0_x == 10'd0 && d0_y == 10'd1) && n < 900);
    chk("reach_line1", int'(d0_x == 10'd0 && d0_y == 10'd1), 1);

    von_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int t = 0; t < 800; t++) begin
      if (d0_von) von_cnt++;
      if (!d0_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d0_x);
        hs_last = int'(d0_x);
      end
      next_tick0(ok);
    end
    chk("line_von_ticks", von_cnt, 640);
    chk("line_hs_ticks",  hs_cnt,  96);
    chk("line_hs_first",  hs_first, 656);
    chk("line_hs_last",   hs_last,  751);

    n = 0;
    while (!(d0_x == 10'd400 && d0_y == 10'd2) && n < 500) begin
      next_tick0(ok);
      n++;
    end
    chk("reach_400_2", int'(d0_x == 10'd400 && d0_y == 10'd2), 1);

    // Mid-frame reset: let the monitor sample this tick, then pull reset.
    #2;
    rst0_n = 1'b0;
    @(negedge clk);
    check_reset0("midrst");
    q0.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1));
    q0.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0));
    @(negedge clk);
    rst0_n = 1'b1;
    first_tick0("restart_tick");
    wait_empty(0, 50);

    // Tiny raster, CLK_DIV=1: idx = x + 15*y, one tick per clk.
    q1.push_back(mk(0,   0,  0, 1, 1, 1, 1, 1));
    q1.push_back(mk(7,   7,  0, 1, 1, 1, 0, 0));
    q1.push_back(mk(8,   8,  0, 1, 1, 0, 0, 0));
    q1.push_back(mk(9,   9,  0, 1, 1, 0, 0, 0));
    q1.push_back(mk(10,  10, 0, 0, 1, 0, 0, 0));
    q1.push_back(mk(12,  12, 0, 0, 1, 0, 0, 0));
    q1.push_back(mk(13,  13, 0, 1, 1, 0, 0, 0));
    q1.push_back(mk(14,  14, 0, 1, 1, 0, 0, 0));
    q1.push_back(mk(15,  0,  1, 1, 1, 1, 1, 0));
    q1.push_back(mk(52,  7,  3, 1, 1, 1, 0, 0));
    q1.push_back(mk(67,  7,  4, 1, 1, 0, 0, 0));
    q1.push_back(mk(74,  14, 4, 1, 1, 0, 0, 0));
    q1.push_back(mk(75,  0,  5, 1, 0, 0, 1, 0));
    q1.push_back(mk(104, 14, 6, 1, 0, 0, 0, 0));
    q1.push_back(mk(105, 0,  7, 1, 1, 0, 1, 0));
    q1.push_back(mk(119, 14, 7, 1, 1, 0, 0, 0));
    q1.push_back(mk(120, 0,  0, 1, 1, 1, 1, 1));
    q1.push_back(mk(121, 1,  0, 1, 1, 1, 0, 0));

    rst1_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      ls_c = 0; fs_c = 0; von_c = 0; vs_c = 0; hs_c = 0; tk_c = 0;
      for (int i = 0; i < 120; i++) begin
        if (d1_tick) tk_c++;
        if (d1_ls)   ls_c++;
        if (d1_fs)   fs_c++;
        if (d1_von)  von_c++;
        if (!d1_vs)  vs_c++;
        if (!d1_hs)  hs_c++;
        @(negedge clk);
      end
      chk("small_tick_cnt", tk_c,  120);
      chk("small_ls_cnt",   ls_c,  8);
      chk("small_fs_cnt",   fs_c,  1);
      chk("small_von_cnt",  von_c, 32);
      chk("small_vs_cnt",   vs_c,  30);
      chk("small_hs_cnt",   hs_c,  24);
    end
    wait_empty(1, 50);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
